// File: rtl/ntt_drain_if.sv
// ntt_drain_if
// Host-side stream leaving the NTT drain buffer.
//   m_data_o  : one beat of NLANE lanes, each lane holding two 64-bit values
//   m_valid_o : a beat is presented on m_data_o
//   m_ready_i : host accepts the presented beat this cycle
//   m_last_o  : presented beat is the final beat of an NTT frame
// The master modport is the drain buffer side; the slave modport is the host.
interface ntt_drain_if #(
  parameter int NLANE = 8
) ();

  logic [NLANE-1:0][1:0][63:0] m_data_o;
  logic                        m_valid_o;
  logic                        m_ready_i;
  logic                        m_last_o;

  modport master (
    output m_data_o,
    output m_valid_o,
    output m_last_o,
    input  m_ready_i
  );

  modport slave (
    input  m_data_o,
    input  m_valid_o,
    input  m_last_o,
    output m_ready_i
  );

endinterface

// File: rtl/ntt_drain.sv
// ntt_drain
// Buffers result beats coming out of an NTT core (which cannot be stalled)
// in a first-word-fall-through FIFO and streams them to the host with a
// valid/ready handshake, marking the last beat of every frame. An upstream
// feeder reserves FIFO space before launching work into the core, so the
// credit output tells it how many slots are neither filled nor promised.
// Ports:
//   clk_i, rst_i  : clock and synchronous active-high reset
//   x_i, valid_i  : beat and per-lane valid from the NTT core
//   reserve_i     : feeder launched one beat into the core
//   credit_o      : DEPTH - occupancy - outstanding reservations
//   m             : host stream (ntt_drain_if master side)
//   err_ovf_o     : sticky, beat dropped on full FIFO or reserve with no credit
//   err_lane_o    : sticky, partial valid_i pattern seen
module ntt_drain #(
  parameter  int NLANE       = 8,
  parameter  int DEPTH       = 64,
  parameter  int FRAME_BEATS = 256,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NLANE-1:0][1:0][63:0] x_i,
  input  logic [NLANE-1:0]            valid_i,
  input  logic                        reserve_i,
  output logic [CW-1:0]               credit_o,
  ntt_drain_if.master                 m,
  output logic                        err_ovf_o,
  output logic                        err_lane_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_BEATS - 1);

  logic [NLANE-1:0][1:0][63:0] r_mem [DEPTH];
  logic [AW-1:0]               r_wrPtr;
  logic [AW-1:0]               r_rdPtr;
  logic [CW-1:0]               r_count;
  logic [CW-1:0]               r_outst;
  logic [FW-1:0]               r_frameCnt;
  logic                        r_errOvf;
  logic                        r_errLane;

  logic          w_full;
  logic          w_pop;
  logic          w_anyValid;
  logic          w_allValid;
  logic          w_push;
  logic          w_drop;
  logic          w_resAccept;
  logic          w_resReject;
  logic [CW-1:0] w_countNext;
  logic [CW-1:0] w_outstNext;

  // A full FIFO can still take a beat if the head leaves in the same cycle,
  // because the head is read combinationally before the slot is overwritten.
  // Any nonzero valid pattern counts as an arrival for credit bookkeeping,
  // but only a complete beat is stored.
  always_comb begin
    w_full      = (r_count == DEPTH_C);
    w_pop       = m.m_valid_o & m.m_ready_i;
    w_anyValid  = |valid_i;
    w_allValid  = &valid_i;
    w_push      = w_allValid & (~w_full | w_pop);
    w_drop      = w_allValid & w_full & ~w_pop;
    w_resAccept = reserve_i & (credit_o != '0);
    w_resReject = reserve_i & (credit_o == '0);
  end

  // Occupancy moves by the net of push and pop.
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + ONE_C;
      2'b01:   w_countNext = r_count - ONE_C;
      default: w_countNext = r_count;
    endcase
  end

  // A reservation and an arrival in the same cycle cancel out. An arrival
  // that was never reserved (feeder misbehaving) must not wrap the counter.
  always_comb begin
    w_outstNext = r_outst;
    if (w_resAccept && !w_anyValid) begin
      w_outstNext = r_outst + ONE_C;
    end else if (!w_resAccept && w_anyValid && (r_outst != '0)) begin
      w_outstNext = r_outst - ONE_C;
    end
  end

  // Control state. Reset discards buffered beats and pending reservations
  // and ignores whatever arrives in the reset cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_frameCnt <= '0;
      r_errOvf   <= 1'b0;
      r_errLane  <= 1'b0;
    end else begin
      r_count <= w_countNext;
      r_outst <= w_outstNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + AW'(1);
        r_frameCnt <= (r_frameCnt == FRAME_LAST) ? '0 : r_frameCnt + FW'(1);
      end
      if (w_drop || w_resReject) begin
        r_errOvf <= 1'b1;
      end
      if (w_anyValid && !w_allValid) begin
        r_errLane <= 1'b1;
      end
    end
  end

  // Storage array has no reset; its contents are only visible through the
  // occupancy-qualified head.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wrPtr] <= x_i;
    end
  end

  assign credit_o    = DEPTH_C - r_count - r_outst;
  assign m.m_valid_o = (r_count != '0);
  assign m.m_data_o  = r_mem[r_rdPtr];
  assign m.m_last_o  = m.m_valid_o & (r_frameCnt == FRAME_LAST);
  assign err_ovf_o   = r_errOvf;
  assign err_lane_o  = r_errLane;

endmodule

// File: tb/tb_ntt_drain.sv
// tb_ntt_drain
// Self-checking bench for ntt_drain. A behavioural model keeps the expected
// FIFO contents in a queue, plus the outstanding count, frame position and
// sticky errors; every cycle the DUT outputs are compared against it. A
// table of short vectors with hand-computed outputs and several hand-written
// sequences cover the corner cases.
module tb_ntt_drain;

  localparam int NLANE       = 8;
  localparam int DEPTH       = 64;
  localparam int FRAME_BEATS = 256;
  localparam int CW          = $clog2(DEPTH) + 1;

  typedef logic [NLANE-1:0][1:0][63:0] beat_t;

  typedef struct {
    logic       rst;
    logic       res;
    logic [7:0] valid;
    int         seed;
    logic       ready;
    int         expCredit;
    logic       expValid;
    logic       expOvf;
    logic       expLane;
  } vec_t;

  logic                clk_i = 1'b0;
  logic                rst_i;
  beat_t               x_i;
  logic [NLANE-1:0]    valid_i;
  logic                reserve_i;
  logic [CW-1:0]       credit_o;
  logic                err_ovf_o;
  logic                err_lane_o;

  ntt_drain_if #(.NLANE(NLANE)) busIf ();

  ntt_drain #(
    .NLANE      (NLANE),
    .DEPTH      (DEPTH),
    .FRAME_BEATS(FRAME_BEATS)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .x_i       (x_i),
    .valid_i   (valid_i),
    .reserve_i (reserve_i),
    .credit_o  (credit_o),
    .m         (busIf.master),
    .err_ovf_o (err_ovf_o),
    .err_lane_o(err_lane_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t sbq[$];
  int    expOutst;
  int    expFrame;
  bit    expOvf;
  bit    expLane;
  bit    modelValid;
  int    checks;
  int    failures;
  vec_t  tbl[11];

  // Lane 0 carries {seed, seed+1}; other lanes carry lane/word tags.
  function automatic beat_t mkBeat(input int seed);
    beat_t b;
    for (int l = 0; l < NLANE; l++) begin
      for (int k = 0; k < 2; k++) begin
        b[l][k] = 64'(seed) + (64'(l) << 32) + (64'(k) << 48);
      end
    end
    b[0][0] = 64'(seed);
    b[0][1] = 64'(seed) + 64'd1;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkBeat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual lane0={%0h,%0h} lane7={%0h,%0h} required lane0={%0h,%0h} lane7={%0h,%0h} t=%0t",
               name, act[0][0], act[0][1], act[7][0], act[7][1],
               exp[0][0], exp[0][1], exp[7][0], exp[7][1], $time);
    end
  endtask

  // Drives one cycle from the falling edge, compares the outputs against the
  // model before the rising edge, advances the model, and returns 1 time
  // unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic res,
                               input logic [7:0] valid, input int seed,
                               input logic ready);
    int  credit;
    bit  pop;
    bit  resAcc;
    bit  anyv;
    bit  allv;
    @(negedge clk_i);
    rst_i           = rst;
    reserve_i       = res;
    valid_i         = valid;
    x_i             = mkBeat(seed);
    busIf.m_ready_i = ready;
    #1;
    credit = DEPTH - sbq.size() - expOutst;
    if (modelValid) begin
      checkOutput("m_valid", 64'(busIf.m_valid_o), 64'(sbq.size() != 0));
      checkOutput("m_last", 64'(busIf.m_last_o),
                  64'((sbq.size() != 0) && (expFrame == FRAME_BEATS - 1)));
      if (sbq.size() != 0) checkBeat("m_data", busIf.m_data_o, sbq[0]);
      checkOutput("credit", 64'(credit_o), 64'(credit));
      checkOutput("err_ovf", 64'(err_ovf_o), 64'(expOvf));
      checkOutput("err_lane", 64'(err_lane_o), 64'(expLane));
    end
    if (rst) begin
      sbq.delete();
      expOutst   = 0;
      expFrame   = 0;
      expOvf     = 1'b0;
      expLane    = 1'b0;
      modelValid = 1'b1;
    end else begin
      pop    = (sbq.size() != 0) && ready;
      anyv   = (valid != 8'h00);
      allv   = (valid == 8'hFF);
      resAcc = res && (credit != 0);
      if (res && credit == 0) expOvf = 1'b1;
      if (anyv && !allv) expLane = 1'b1;
      if (resAcc && !anyv) expOutst++;
      else if (!resAcc && anyv && expOutst > 0) expOutst--;
      if (allv && !(sbq.size() < DEPTH || pop)) expOvf = 1'b1;
      if (allv && (sbq.size() < DEPTH || pop)) begin
        if (pop) begin
          void'(sbq.pop_front());
          expFrame = (expFrame + 1) % FRAME_BEATS;
        end
        sbq.push_back(mkBeat(seed));
      end else if (pop) begin
        void'(sbq.pop_front());
        expFrame = (expFrame + 1) % FRAME_BEATS;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int r;
    checks          = 0;
    failures        = 0;
    modelValid      = 1'b0;
    expOutst        = 0;
    expFrame        = 0;
    expOvf          = 1'b0;
    expLane         = 1'b0;
    rst_i           = 1'b1;
    reserve_i       = 1'b0;
    valid_i         = '0;
    x_i             = '0;
    busIf.m_ready_i = 1'b0;

    //          rst   res   valid  seed ready credit vld ovf lane
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 64, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 63, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'hFF, 1, 1'b1, 63, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 64, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 63, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h0F, 9, 1'b1, 64, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 63, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 62, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 8'hFF, 3, 1'b0, 61, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 62, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 0, 1'b0, 64, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk_i);

    // Table: passthrough, lane error, simultaneous reserve and arrival.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].res, tbl[i].valid, tbl[i].seed, tbl[i].ready);
      checkOutput($sformatf("tbl%0d_credit", i), 64'(credit_o), 64'(tbl[i].expCredit));
      checkOutput($sformatf("tbl%0d_valid", i), 64'(busIf.m_valid_o), 64'(tbl[i].expValid));
      checkOutput($sformatf("tbl%0d_ovf", i), 64'(err_ovf_o), 64'(tbl[i].expOvf));
      checkOutput($sformatf("tbl%0d_lane", i), 64'(err_lane_o), 64'(tbl[i].expLane));
      if (i == 2) checkOutput("tbl2_lane0", busIf.m_data_o[0][0], 64'd1);
      if (i == 2) checkOutput("tbl2_lane0b", busIf.m_data_o[0][1], 64'd2);
    end

    // Frame boundary: 257 back-to-back beats with the host always ready.
    for (int i = 0; i <= FRAME_BEATS; i++) begin
      applyStimulus(1'b0, 1'b0, 8'hFF, i, 1'b1);
      if (i == FRAME_BEATS - 1) begin
        checkOutput("frame_last255", 64'(busIf.m_last_o), 64'd1);
        checkOutput("frame_idx255", busIf.m_data_o[0][0], 64'd255);
      end
      if (i == FRAME_BEATS) begin
        checkOutput("frame_next_last", 64'(busIf.m_last_o), 64'd0);
        checkOutput("frame_next_idx", busIf.m_data_o[0][0], 64'd256);
      end
      if (i == 100) checkOutput("frame_mid_last", 64'(busIf.m_last_o), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 1'b1);

    // Backpressure: fill, overflow, then drain in order.
    applyStimulus(1'b1, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'hFF, 1000 + i, 1'b0);
    checkOutput("bp_credit0", 64'(credit_o), 64'd0);
    checkOutput("bp_head", busIf.m_data_o[0][0], 64'd1000);
    checkOutput("bp_no_ovf", 64'(err_ovf_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 8'hFF, 1064, 1'b0);
    checkOutput("bp_ovf", 64'(err_ovf_o), 64'd1);
    checkOutput("bp_head_kept", busIf.m_data_o[0][0], 64'd1000);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'h00, 0, 1'b1);
    checkOutput("bp_empty", 64'(busIf.m_valid_o), 64'd0);

    // Full FIFO with arrival and read together: no error, stays full.
    applyStimulus(1'b1, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'hFF, 2000 + i, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'hFF, 2064 + i, 1'b1);
    checkOutput("fr_no_ovf", 64'(err_ovf_o), 64'd0);
    checkOutput("fr_credit0", 64'(credit_o), 64'd0);
    checkOutput("fr_head", busIf.m_data_o[0][0], 64'd2005);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 8'h00, 0, 1'b1);

    // Reset mid-frame with buffered beats, reservations and sticky errors.
    applyStimulus(1'b0, 1'b1, 8'h00, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h33, 0, 1'b0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0, 8'hFF, 3000 + i, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h00, 0, 1'b0);
    checkOutput("rm_credit_pre", 64'(credit_o), 64'(DEPTH - 10 - 3));
    applyStimulus(1'b1, 1'b1, 8'hFF, 4000, 1'b1);
    checkOutput("rm_valid", 64'(busIf.m_valid_o), 64'd0);
    checkOutput("rm_credit", 64'(credit_o), 64'(DEPTH));
    checkOutput("rm_ovf", 64'(err_ovf_o), 64'd0);
    checkOutput("rm_lane", 64'(err_lane_o), 64'd0);
    for (int i = 0; i < FRAME_BEATS; i++) begin
      applyStimulus(1'b0, 1'b0, 8'hFF, 5000 + i, 1'b1);
      if (i == FRAME_BEATS - 1) checkOutput("rm_last255", 64'(busIf.m_last_o), 64'd1);
      if (i == FRAME_BEATS - 2) checkOutput("rm_last254", 64'(busIf.m_last_o), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 0, 1'b1);

    // Random traffic against the model.
    applyStimulus(1'b1, 1'b0, 8'h00, 0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      r = int'($urandom_range(0, 99));
      if (r < 80) v = 8'hFF;
      else if (r < 94) v = 8'h00;
      else v = 8'($urandom_range(1, 254));
      applyStimulus(1'b0, 1'($urandom_range(0, 99) < 35), v, 6000 + i,
                    1'($urandom_range(0, 99) < 55));
    end
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 1'b0, 8'h00, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_drain.md
NTT_DRAIN -- requirements
Module: ntt_drain

Interface
REQ-001 Parameter NLANE, default 8: lanes per beat; each lane carries 2x64-bit values.
REQ-002 Parameter DEPTH, default 64: beat FIFO depth; power of two, >= 4.
REQ-003 Parameter FRAME_BEATS, default 256: output beats per NTT frame (2^12 points / (NLANE*2)).
REQ-004 Local CW = $clog2(DEPTH)+1, the width of the occupancy and credit counters.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 x_i  input  [NLANE-1:0][1:0][63:0]  result data from the NTT core output.
REQ-008 valid_i  input  [NLANE-1:0]  per-lane valid from the core; no backpressure toward the core.
REQ-009 reserve_i  input  1  upstream feeder launched one input beat into the core; reserves one FIFO slot.
REQ-010 credit_o  output  CW  free slots not yet reserved: DEPTH - occupancy - outstanding.
REQ-011 m_data_o  output  [NLANE-1:0][1:0][63:0]  host-side stream data.
REQ-012 m_valid_o  output  1  host stream valid.
REQ-013 m_ready_i  input  1  host stream ready.
REQ-014 m_last_o  output  1  high on the final beat of each frame.
REQ-015 err_ovf_o  output  1  sticky: beat dropped on full FIFO, or reserve_i issued with credit_o==0.
REQ-016 err_lane_o  output  1  sticky: partial valid_i pattern seen.

Function
REQ-017 Arrival: valid_i all ones; beat written to FIFO at the tail.
REQ-018 Partial arrival: valid_i nonzero and not all ones; beat dropped, err_lane_o set next cycle.
REQ-019 Arrival with FIFO full and no read in the same cycle: beat dropped, err_ovf_o set; FIFO contents unchanged.
REQ-020 Arrival with FIFO full and a read handshake in the same cycle: write accepted; occupancy stays DEPTH.
REQ-021 FIFO is first-word-fall-through; m_valid_o = (occupancy != 0); m_data_o = head entry.
REQ-022 Latency: a beat arriving at cycle N into an empty FIFO is presented on m_data_o/m_valid_o at cycle N+1.
REQ-023 Handshake: m_valid_o & m_ready_i pops the head; m_data_o and m_last_o stay stable while m_valid_o & !m_ready_i.
REQ-024 Ordering: beats leave in arrival order; pointers wrap modulo DEPTH.
REQ-025 Frame counter: increments on each output handshake; wraps FRAME_BEATS-1 -> 0.
REQ-026 m_last_o = m_valid_o & (frame counter == FRAME_BEATS-1).
REQ-027 Outstanding counter (CW bits): +1 on an accepted reserve_i; -1 on any arrival (full, partial or dropped).
REQ-028 Simultaneous reserve_i and arrival leave the outstanding counter unchanged.
REQ-029 Arrival with outstanding==0: counter saturates at 0 (no underflow).
REQ-030 reserve_i with credit_o==0: reservation ignored, err_ovf_o set.
REQ-031 credit_o is combinational from registered occupancy and outstanding; it never exceeds DEPTH and is never negative.
REQ-032 Sticky errors clear only on rst_i.

Reset
REQ-033 rst_i high at a clock edge: pointers, occupancy, outstanding counter and frame counter go to 0; err_ovf_o=0, err_lane_o=0.
REQ-034 Output values during and after reset: m_valid_o=0, m_last_o=0, credit_o=DEPTH.
REQ-035 rst_i mid-frame or mid-stream discards buffered beats and pending reservations.
REQ-036 No arrival or reserve_i is acted on in a cycle with rst_i high.
REQ-037 m_data_o is don't-care while m_valid_o=0.

Verification
REQ-038 Passthrough: after reset, pulse reserve_i, then one all-ones valid_i beat with lane0={1,2}, m_ready_i=1 -> credit_o goes 64->63->64; m_valid_o=1 one cycle later with lane0={1,2}.
REQ-039 Frame: 256 consecutive beats carrying lane0[0]=index, m_ready_i=1 -> m_last_o only on index 255; the next beat (index 0 of the next frame) has m_last_o=0.
REQ-040 Backpressure: m_ready_i=0, 64 beats in -> credit_o=0 and data held stable; 65th beat -> dropped and err_ovf_o=1; drain -> beats 0..63 in order.
REQ-041 Full + read: FIFO full, arrival and handshake in the same cycle -> no error; occupancy stays 64; order preserved.
REQ-042 Lane error: valid_i=8'h0F -> nothing enqueued, err_lane_o=1, outstanding decremented.
REQ-043 Reset mid-frame: 10 beats buffered, 3 reserved, rst_i for 1 cycle -> m_valid_o=0, credit_o=64, errors 0, frame counter restarts at 0.
